// File: rtl/xyolo_vwrite_serializer.sv
// xyolo_vwrite_serializer
// Accepts N_LANES-wide vectors into a small FIFO and writes them out one lane
// per databus transaction. Lane l of entry e goes to
//   ext_addr + e*entry_incr + l*lane_incr   (modulo 2^IO_ADDR_W),
// and the address is built with running adders rather than multipliers.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   run              : one-cycle start pulse, latches cfg_*; also aborts a job
//   done             : high in DONE until the next run pulse
//   cfg_ext_addr     : base address of the job
//   cfg_nentries     : number of vectors in the job
//   cfg_nlanes       : active lanes per vector (0 or >N_LANES means N_LANES)
//   cfg_lane_incr    : address step between lanes
//   cfg_entry_incr   : address step between vectors
//   in_valid/in_ready/in_data : vector input, lane 0 in the MSBs
//   databus_valid/ready/addr/wdata/wstrb : single-word write request port
module xyolo_vwrite_serializer #(
  parameter int DATA_W    = 32,
  parameter int N_LANES   = 4,
  parameter int DEPTH     = 8,
  parameter int IO_ADDR_W = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  output logic                         done,
  input  logic [IO_ADDR_W-1:0]         cfg_ext_addr,
  input  logic [15:0]                  cfg_nentries,
  input  logic [$clog2(N_LANES+1)-1:0] cfg_nlanes,
  input  logic [IO_ADDR_W-1:0]         cfg_lane_incr,
  input  logic [IO_ADDR_W-1:0]         cfg_entry_incr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_LANES*DATA_W-1:0]    in_data,
  output logic                         databus_valid,
  input  logic                         databus_ready,
  output logic [IO_ADDR_W-1:0]         databus_addr,
  output logic [DATA_W-1:0]            databus_wdata,
  output logic [DATA_W/8-1:0]          databus_wstrb
);

  localparam int LW = $clog2(N_LANES+1);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int VW = N_LANES * DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_done;
  logic [15:0]          r_nentries;
  logic [LW-1:0]        r_nlanes;
  logic [IO_ADDR_W-1:0] r_lane_incr;
  logic [IO_ADDR_W-1:0] r_entry_incr;
  logic [PW-1:0]        r_wptr;
  logic [PW-1:0]        r_rptr;
  logic [CW-1:0]        r_count;
  logic [15:0]          r_accepted;
  logic [15:0]          r_popped;
  logic [LW-1:0]        r_lane;
  logic [IO_ADDR_W-1:0] r_entry_addr;   // address of lane 0 of the head entry
  logic [IO_ADDR_W-1:0] r_addr;         // address of the lane being presented
  logic [VW-1:0]        r_mem [DEPTH];

  logic                 w_run_st;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_in_ready;
  logic                 w_bus_valid;
  logic                 w_push;
  logic                 w_bus_hs;
  logic                 w_last_lane;
  logic                 w_last_entry;
  logic                 w_pop;
  logic [LW-1:0]        w_nlanes_eff;
  logic [IO_ADDR_W-1:0] w_next_entry_addr;
  logic [VW-1:0]        w_head;
  logic [DATA_W-1:0]    w_lane_word;

  assign w_run_st          = (r_state == ST_RUN);
  assign w_full            = (r_count == CW'(DEPTH));
  assign w_empty           = (r_count == {CW{1'b0}});
  assign w_in_ready        = w_run_st && !w_full && (r_accepted < r_nentries);
  assign w_bus_valid       = w_run_st && !w_empty;
  assign w_push            = in_valid && w_in_ready;
  assign w_bus_hs          = w_bus_valid && databus_ready;
  assign w_last_lane       = (r_lane == (r_nlanes - LW'(1)));
  assign w_last_entry      = (r_popped == (r_nentries - 16'd1));
  assign w_pop             = w_bus_hs && w_last_lane;
  assign w_next_entry_addr = r_entry_addr + r_entry_incr;
  assign w_head            = r_mem[r_rptr];

  // Out-of-range lane counts collapse to the full vector width.
  assign w_nlanes_eff = ((cfg_nlanes == {LW{1'b0}}) || (cfg_nlanes > LW'(N_LANES)))
                        ? LW'(N_LANES) : cfg_nlanes;

  // Select the current lane word from the FIFO head (lane 0 in the MSBs).
  always_comb begin
    w_lane_word = {DATA_W{1'b0}};
    for (int j = 0; j < N_LANES; j++) begin
      w_lane_word = (r_lane == LW'(j)) ? w_head[VW-1-DATA_W*j -: DATA_W] : w_lane_word;
    end
  end

  // FIFO storage; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= in_data;
    end
  end

  // Job FSM, FIFO pointers/occupancy, lane/entry counters and address adders.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_done       <= 1'b0;
      r_nentries   <= 16'd0;
      r_nlanes     <= {LW{1'b0}};
      r_lane_incr  <= {IO_ADDR_W{1'b0}};
      r_entry_incr <= {IO_ADDR_W{1'b0}};
      r_wptr       <= {PW{1'b0}};
      r_rptr       <= {PW{1'b0}};
      r_count      <= {CW{1'b0}};
      r_accepted   <= 16'd0;
      r_popped     <= 16'd0;
      r_lane       <= {LW{1'b0}};
      r_entry_addr <= {IO_ADDR_W{1'b0}};
      r_addr       <= {IO_ADDR_W{1'b0}};
    end else if (run) begin
      // Start (or abort and restart): anything in flight this cycle,
      // including a vector handed over right now, belongs to the old job.
      r_state      <= ST_RUN;
      r_done       <= 1'b0;
      r_nentries   <= cfg_nentries;
      r_nlanes     <= w_nlanes_eff;
      r_lane_incr  <= cfg_lane_incr;
      r_entry_incr <= cfg_entry_incr;
      r_wptr       <= {PW{1'b0}};
      r_rptr       <= {PW{1'b0}};
      r_count      <= {CW{1'b0}};
      r_accepted   <= 16'd0;
      r_popped     <= 16'd0;
      r_lane       <= {LW{1'b0}};
      r_entry_addr <= cfg_ext_addr;
      r_addr       <= cfg_ext_addr;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_nentries == 16'd0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            if (w_push) begin
              r_wptr     <= r_wptr + PW'(1);
              r_accepted <= r_accepted + 16'd1;
            end
            if (w_bus_hs) begin
              if (w_last_lane) begin
                r_rptr       <= r_rptr + PW'(1);
                r_lane       <= {LW{1'b0}};
                r_popped     <= r_popped + 16'd1;
                r_entry_addr <= w_next_entry_addr;
                r_addr       <= w_next_entry_addr;
                if (w_last_entry) begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                end
              end else begin
                r_lane <= r_lane + LW'(1);
                r_addr <= r_addr + r_lane_incr;
              end
            end
            case ({w_push, w_pop})
              2'b10:   r_count <= r_count + CW'(1);
              2'b01:   r_count <= r_count - CW'(1);
              default: r_count <= r_count;
            endcase
          end
        end
        ST_IDLE, ST_DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // All outputs decode registered state only; data/address read 0 when idle.
  assign done          = r_done;
  assign in_ready      = w_in_ready;
  assign databus_valid = w_bus_valid;
  assign databus_addr  = w_bus_valid ? r_addr : {IO_ADDR_W{1'b0}};
  assign databus_wdata = w_bus_valid ? w_lane_word : {DATA_W{1'b0}};
  assign databus_wstrb = w_bus_valid ? {(DATA_W/8){1'b1}} : {(DATA_W/8){1'b0}};

endmodule

// File: tb/tb_xyolo_vwrite_serializer.sv
// Scoreboard bench for xyolo_vwrite_serializer (default parameters).
// Drivers push expected writes into sb_q; a negedge monitor pops and compares
// on every databus handshake and checks address/data stability while stalled.
module tb_xyolo_vwrite_serializer;

  localparam int DW = 32;
  localparam int NL = 4;
  localparam int DP = 8;
  localparam int AW = 32;
  localparam int VW = NL * DW;
  localparam int LW = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk;
  logic          rst_n;
  logic          run;
  logic          done;
  logic [AW-1:0] cfg_ext_addr;
  logic [15:0]   cfg_nentries;
  logic [LW-1:0] cfg_nlanes;
  logic [AW-1:0] cfg_lane_incr;
  logic [AW-1:0] cfg_entry_incr;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          databus_valid;
  logic          databus_ready;
  logic [AW-1:0] databus_addr;
  logic [DW-1:0] databus_wdata;
  logic [DW/8-1:0] databus_wstrb;

  wr_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  int  last_hs_cyc = 0;
  int  hs_count = 0;
  int  pushed = 0;

  logic [AW-1:0] t1_addr [8] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C,
                                 32'h0000_1100, 32'h0000_1104, 32'h0000_1108, 32'h0000_110C};
  logic [DW-1:0] t1_data [8] = '{32'h0A00_0000, 32'h0A00_0001, 32'h0A00_0002, 32'h0A00_0003,
                                 32'h0A00_0100, 32'h0A00_0101, 32'h0A00_0102, 32'h0A00_0103};

  xyolo_vwrite_serializer #(
    .DATA_W(DW), .N_LANES(NL), .DEPTH(DP), .IO_ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .done(done),
    .cfg_ext_addr(cfg_ext_addr), .cfg_nentries(cfg_nentries), .cfg_nlanes(cfg_nlanes),
    .cfg_lane_incr(cfg_lane_incr), .cfg_entry_incr(cfg_entry_incr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .databus_valid(databus_valid), .databus_ready(databus_ready),
    .databus_addr(databus_addr), .databus_wdata(databus_wdata), .databus_wstrb(databus_wstrb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timeout waiting for DUT", nm);
  endtask

  function automatic logic [VW-1:0] mk_vec(input logic [23:0] tag);
    logic [VW-1:0] v;
    v = '0;
    for (int l = 0; l < NL; l++) v[VW-1-DW*l -: DW] = {tag, 8'(l)};
    return v;
  endfunction

  task automatic exp_vec(input logic [AW-1:0] base, input int e, input int nl,
                         input logic [AW-1:0] li, input logic [AW-1:0] ei,
                         input logic [VW-1:0] vec);
    wr_t w;
    for (int l = 0; l < nl; l++) begin
      w.addr = base + AW'(e) * ei + AW'(l) * li;
      w.data = vec[VW-1-DW*l -: DW];
      sb_q.push_back(w);
    end
  endtask

  task automatic do_run(input logic [AW-1:0] base, input logic [15:0] n, input logic [LW-1:0] nl,
                        input logic [AW-1:0] li, input logic [AW-1:0] ei);
    run = 1'b1;
    cfg_ext_addr = base;
    cfg_nentries = n;
    cfg_nlanes = nl;
    cfg_lane_incr = li;
    cfg_entry_incr = ei;
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  task automatic push_vec(input logic [VW-1:0] vec);
    int waited;
    bit ok;
    waited = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = vec;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waited++;
      if (waited > 300) break;
    end
    if (!ok) fail_now("push");
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (ok) pushed++;
  endtask

  task automatic wait_done(input string nm);
    int waited;
    bit ok;
    waited = 0;
    ok = 1'b0;
    forever begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
      waited++;
      if (waited > 2000) break;
    end
    if (!ok) begin
      fail_now(nm);
    end else begin
      chk({nm, "_done_cycle"}, 64'(cyc), 64'(last_hs_cyc + 1));
      chk({nm, "_sb_left"}, 64'(sb_q.size()), 64'd0);
      chk({nm, "_done_in_ready"}, 64'(in_ready), 64'd0);
      chk({nm, "_done_valid"}, 64'(databus_valid), 64'd0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({nm, "_valid"}, 64'(databus_valid), 64'd0);
    chk({nm, "_wstrb"}, 64'(databus_wstrb), 64'd0);
    chk({nm, "_addr"}, 64'(databus_addr), 64'd0);
    chk({nm, "_wdata"}, 64'(databus_wdata), 64'd0);
  endtask

  // Monitor: handshake scoreboard plus hold-stability while stalled.
  initial begin
    bit stall_q;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    wr_t w;
    stall_q = 1'b0;
    st_addr = '0;
    st_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_q = 1'b0;
      end else if (databus_valid) begin
        if (stall_q) begin
          chk("hold_addr", 64'(databus_addr), 64'(st_addr));
          chk("hold_data", 64'(databus_wdata), 64'(st_data));
        end
        if (databus_ready) begin
          hs_count++;
          last_hs_cyc = cyc;
          chk("wr_wstrb", 64'(databus_wstrb), 64'hF);
          if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                     databus_addr, databus_wdata);
          end else begin
            w = sb_q.pop_front();
            chk("wr_addr", 64'(databus_addr), 64'(w.addr));
            chk("wr_data", 64'(databus_wdata), 64'(w.data));
          end
        end
        stall_q = !databus_ready;
        st_addr = databus_addr;
        st_data = databus_wdata;
      end else begin
        stall_q = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hs0;
    rst_n = 1'b0;
    run = 1'b0;
    cfg_ext_addr = '0;
    cfg_nentries = '0;
    cfg_nlanes = '0;
    cfg_lane_incr = '0;
    cfg_entry_incr = '0;
    in_valid = 1'b0;
    in_data = '0;
    databus_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic order and addresses, ready held high.
    databus_ready = 1'b1;
    for (int i = 0; i < 8; i++) sb_q.push_back('{t1_addr[i], t1_data[i]});
    do_run(32'h1000, 16'd2, 3'd4, 32'h4, 32'h100);
    push_vec(mk_vec(24'h0A0000));
    push_vec(mk_vec(24'h0A0001));
    wait_done("basic");

    // Full FIFO and backpressure: 10 vectors, ready low until in_ready drops.
    databus_ready = 1'b0;
    pushed = 0;
    do_run(32'h3000, 16'd10, 3'd4, 32'h4, 32'h10);
    for (int i = 0; i < 10; i++) exp_vec(32'h3000, i, 4, 32'h4, 32'h10, mk_vec(24'h0B0000 + 24'(i)));
    fork
      begin
        for (int i = 0; i < 10; i++) push_vec(mk_vec(24'h0B0000 + 24'(i)));
      end
      begin
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("bp_pushed", 64'(pushed), 64'd8);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        databus_ready = 1'b1;
      end
    join
    wait_done("backpressure");

    // Partial lanes: nlanes=2, then nlanes=0 and nlanes=7 (both mean 4).
    do_run(32'h4000, 16'd3, 3'd2, 32'h8, 32'h40);
    for (int i = 0; i < 3; i++) begin
      exp_vec(32'h4000, i, 2, 32'h8, 32'h40, mk_vec(24'h0C0000 + 24'(i)));
      push_vec(mk_vec(24'h0C0000 + 24'(i)));
    end
    wait_done("nlanes2");
    do_run(32'h5000, 16'd2, 3'd0, 32'h4, 32'h20);
    for (int i = 0; i < 2; i++) begin
      exp_vec(32'h5000, i, 4, 32'h4, 32'h20, mk_vec(24'h0D0000 + 24'(i)));
      push_vec(mk_vec(24'h0D0000 + 24'(i)));
    end
    wait_done("nlanes0");
    do_run(32'h5800, 16'd1, 3'd7, 32'h4, 32'h0);
    exp_vec(32'h5800, 0, 4, 32'h4, 32'h0, mk_vec(24'h0E0000));
    push_vec(mk_vec(24'h0E0000));
    wait_done("nlanes7");

    // Zero entries: done one cycle after the run edge, never valid.
    do_run(32'h9000, 16'd0, 3'd4, 32'h4, 32'h10);
    @(negedge clk);
    chk("zero_done_early", 64'(done), 64'd0);
    chk("zero_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_valid", 64'(databus_valid), 64'd0);
    @(posedge clk); #1;

    // Abort: three stale entries queued, then a new job at 0x2000.
    databus_ready = 1'b0;
    do_run(32'h6000, 16'd5, 3'd4, 32'h4, 32'h100);
    for (int i = 0; i < 3; i++) push_vec(mk_vec(24'h0F0000 + 24'(i)));
    do_run(32'h2000, 16'd1, 3'd4, 32'h4, 32'h100);
    exp_vec(32'h2000, 0, 4, 32'h4, 32'h100, mk_vec(24'h1A0000));
    databus_ready = 1'b1;
    push_vec(mk_vec(24'h1A0000));
    wait_done("abort");

    // Mid-transfer reset: outputs drop at once, nothing written afterwards.
    databus_ready = 1'b0;
    do_run(32'h7000, 16'd4, 3'd4, 32'h4, 32'h10);
    push_vec(mk_vec(24'h1B0000));
    push_vec(mk_vec(24'h1B0001));
    @(negedge clk);
    chk("pre_reset_valid", 64'(databus_valid), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_idle("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    databus_ready = 1'b1;
    hs0 = hs_count;
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_writes", 64'(hs_count), 64'(hs0));
    do_run(32'h8000, 16'd1, 3'd3, 32'h10, 32'h0);
    exp_vec(32'h8000, 0, 3, 32'h10, 32'h0, mk_vec(24'h1C0000));
    push_vec(mk_vec(24'h1C0000));
    wait_done("after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/xyolo_vwrite_serializer.md
XYOLO_VWRITE_SERIALIZER -- requirements
Module: xyolo_vwrite_serializer

Interface
REQ-001 Parameter DATA_W, default 32, the width of one lane word and of the databus word.
REQ-002 Parameter N_LANES, default 4, the number of parallel lanes; must be ≥1.
REQ-003 Parameter DEPTH, default 8, the number of entries in the vector FIFO; must be a power of 2 and ≥2.
REQ-004 Parameter IO_ADDR_W, default 32, the external address width.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, width 1: the single clock.
REQ-007 Port rst_n, input, width 1: asynchronous reset, active low.
REQ-008 Port run, input, width 1: one-cycle start pulse; it latches the cfg_* inputs.
REQ-009 Port done, output, width 1: high once every configured entry has been written.
REQ-010 Port cfg_ext_addr, input, IO_ADDR_W bits: external base address.
REQ-011 Port cfg_nentries, input, 16 bits: number of vectors to write.
REQ-012 Port cfg_nlanes, input, $clog2(N_LANES+1) bits: number of active lanes per vector.
REQ-013 Port cfg_lane_incr, input, IO_ADDR_W bits: address step between lanes.
REQ-014 Port cfg_entry_incr, input, IO_ADDR_W bits: address step between vectors.
REQ-015 Port in_valid, input, width 1: an input vector is offered.
REQ-016 Port in_ready, output, width 1: the block accepts the offered vector.
REQ-017 Port in_data, input, N_LANES*DATA_W bits: the input vector; lane j occupies bits [N_LANES*DATA_W-DATA_W*j-1 -: DATA_W], so lane 0 is in the MSBs.
REQ-018 Port databus_valid, output, width 1: a write request is presented.
REQ-019 Port databus_ready, input, width 1: the current write is accepted.
REQ-020 Port databus_addr, output, IO_ADDR_W bits: write address.
REQ-021 Port databus_wdata, output, DATA_W bits: write data.
REQ-022 Port databus_wstrb, output, DATA_W/8 bits: write byte strobes.

Function
REQ-023 The FSM SHALL have three states, IDLE, RUN and DONE, and transition as follows.
- Any state -> RUN on run=1; the cfg_* inputs are latched, and the FIFO and all counters are cleared.
- RUN -> DONE on the databus handshake of the last lane of entry cfg_nentries-1.
- RUN with latched nentries=0 -> DONE on the next cycle.
- A run pulse while in RUN aborts the current job: pending FIFO contents are discarded and the new job starts.
REQ-024 A latched nlanes of 0 or greater than N_LANES SHALL be treated as N_LANES.
REQ-025 in_ready SHALL be asserted only when all of the following hold: state is RUN, the FIFO is not full, and the number of accepted vectors is less than nentries.
REQ-026 A vector SHALL be pushed into the FIFO on in_valid & in_ready; in_data is stored unmodified.
REQ-027 databus_valid SHALL be asserted when state is RUN and the FIFO is not empty; it is driven from registered state only, with no combinational path from databus_ready.
REQ-028 For head entry e and lane l, databus_wdata SHALL equal lane l of that entry.
REQ-029 For head entry e and lane l, databus_addr SHALL equal cfg_ext_addr + e*entry_incr + l*lane_incr, modulo 2^IO_ADDR_W.
- The address is generated incrementally from registered adders; no multipliers are used.
REQ-030 Lanes SHALL be emitted in the order 0..nlanes-1.
- The lane counter advances only on databus_valid & databus_ready.
- After the last lane, the entry is popped, the lane counter returns to 0 and e increments.
REQ-031 databus_valid, databus_addr and databus_wdata SHALL hold stable while databus_valid=1 and databus_ready=0.
REQ-032 databus_wstrb SHALL be all ones when databus_valid=1 and all zeros otherwise.
REQ-033 Latency: a vector pushed at edge t SHALL present lane 0 on the databus from cycle t+1 if the FIFO was empty.
REQ-034 A push and a pop in the same cycle SHALL both take effect and leave the FIFO occupancy unchanged.
- A push is blocked only when the FIFO is full, even if a pop occurs in the same cycle.
REQ-035 The FIFO read and write pointers SHALL wrap modulo DEPTH; the occupancy counter spans 0..DEPTH.
REQ-036 done SHALL be 1 exactly in state DONE and hold until the next run pulse.
- In DONE, in_ready=0 and databus_valid=0.

Reset
REQ-037 On rst_n=0, the block SHALL asynchronously go to IDLE.
- FIFO empty, all pointers and counters 0.
- done=0, in_ready=0, databus_valid=0, databus_wstrb=0, databus_addr=0, databus_wdata=0.
REQ-038 A reset asserted mid-transfer SHALL discard all pending data; no write is issued after the reset is released until a new run pulse.

Verification
REQ-039 Basic write order and addresses.
- Stimulus: N_LANES=4; run with base=0x1000, nentries=2, nlanes=4, lane_incr=4, entry_incr=0x100; two vectors; databus_ready held 1.
- Response: 8 writes at 0x1000, 0x1004, 0x1008, 0x100C, 0x1100, ..., 0x110C with the lane words in order; done=1 the cycle after the 8th handshake.
REQ-040 Full FIFO and backpressure.
- Stimulus: DEPTH=8, databus_ready=0, 10 vectors offered.
- Response: in_ready drops after 8 pushes; the address and data stay stable; releasing databus_ready drains all 10 in order.
REQ-041 Partial lanes.
- Stimulus: nlanes=2 and, separately, nlanes=0.
- Response: nlanes=2 gives 2 writes per vector, lanes 0 and 1 only; nlanes=0 gives 4 writes per vector.
REQ-042 Zero entries.
- Stimulus: run with nentries=0.
- Response: done=1 one cycle later with no databus_valid.
REQ-043 Aborting run.
- Stimulus: a new run pulse mid-job, with 3 entries queued and base 0x2000.
- Response: the old entries are never written; the first write is at 0x2000 with new-job data.
REQ-044 Mid-transfer reset.
- Stimulus: rst_n pulsed low mid-transfer.
- Response: all outputs are 0 immediately; nothing is written until the next run pulse.
